flash_read_responder: RTL

FLASH_READ_RESPONDER -- requirements
Module: flash_read_responder

---
 rtl/flash_resp_pkg.sv | 19 +
 rtl/resp_pipe.sv | 26 ++
 rtl/flash_read_responder.sv | 83 ++++++++
 3 files changed

// File: rtl/flash_resp_pkg.sv
// flash_resp_pkg: shared states, parameter defaults/limits and lane masking for the flash read responder
package flash_resp_pkg;
  typedef enum logic {IDLE, STALL} state_t;
  typedef struct packed {
    logic       valid;
    logic [3:0] be;
    logic       rng;
  } resp_t;
  localparam int          WAIT_CYCLES_DEF = 1;
  localparam int          LATENCY_DEF     = 2;
  localparam int          MAX_PENDING_DEF = 1;
  localparam logic [22:0] MEM_WORDS_DEF   = 23'd2097152;
  localparam int          WAIT_MAX        = 7;
  localparam int          LATENCY_MIN     = 1;
  localparam int          LATENCY_MAX     = 4;
  function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] be);
    return d & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/resp_pipe.sv
// resp_pipe: LATENCY-deep shift of per-read response control (valid, lane enables, range flag)
module resp_pipe
  import flash_resp_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_be,
  input  logic       in_rng,
  output logic       out_valid,
  output logic [3:0] out_be,
  output logic       out_rng
);
  resp_t [LATENCY-1:0] stage;
  always_ff @(posedge clk or negedge reset)
    if (!reset) stage <= '0;
    else begin
      stage[0] <= '{valid: in_valid, be: in_be, rng: in_rng};
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  assign out_valid = stage[LATENCY-1].valid;
  assign out_be    = stage[LATENCY-1].be;
  assign out_rng   = stage[LATENCY-1].rng;
endmodule

// File: rtl/flash_read_responder.sv
// flash_read_responder: wait-stalled, fixed-latency read responder in front of a synchronous ROM
module flash_read_responder
  import flash_resp_pkg::*;
#(
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int          LATENCY     = LATENCY_DEF,
  parameter int          MAX_PENDING = MAX_PENDING_DEF,
  parameter logic [22:0] MEM_WORDS   = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read,
  input  logic [22:0] address,
  input  logic [3:0]  byteEnable,
  output logic        waitRequest,
  output logic [31:0] readData,
  output logic        readDataValid,
  output logic        rangeError,
  output logic        mem_rd,
  output logic [22:0] mem_addr,
  input  logic [31:0] mem_data
);
  localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);
  localparam logic [2:0] PEND_C = 3'(MAX_PENDING);
  state_t      state, state_nxt;
  logic [2:0]  stall_cnt, pending;
  logic [22:0] addr_q;
  logic        accept, in_range, ret_valid, ret_rng;
  logic [3:0]  ret_be;
  logic [31:0] ret_data;
  assign in_range    = address < MEM_WORDS;
  assign waitRequest = read && (!reset || stall_cnt < WAIT_C || pending == PEND_C);
  assign accept      = read && !waitRequest;
  assign mem_rd      = accept && in_range;
  assign mem_addr    = mem_rd ? address : addr_q;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (waitRequest ? STALL : IDLE) : ((!read || accept) ? IDLE : STALL);
  end
  // pending drops on the edge that launches readDataValid, so a full pipe reopens as the response appears
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      stall_cnt <= '0;
      pending   <= '0;
      addr_q    <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= (!read || accept) ? '0 : (stall_cnt == 3'(WAIT_MAX)) ? stall_cnt : stall_cnt + 3'd1;
      pending   <= pending + {2'b0, accept} - {2'b0, ret_valid};
      if (mem_rd) addr_q <= address;
    end
  resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_be     (byteEnable),
    .in_rng    (!in_range),
    .out_valid (ret_valid),
    .out_be    (ret_be),
    .out_rng   (ret_rng)
  );
  if (LATENCY == 1) begin : g_direct
    assign ret_data = mem_data;
  end else begin : g_delay
    logic [31:0] dl [LATENCY-1];
    always_ff @(posedge clk) begin
      dl[0] <= mem_data;
      for (int i = 1; i < LATENCY - 1; i++) dl[i] <= dl[i-1];
    end
    assign ret_data = dl[LATENCY-2];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      readData      <= '0;
      readDataValid <= 1'b0;
      rangeError    <= 1'b0;
    end else begin
      readDataValid <= ret_valid;
      rangeError    <= ret_valid && ret_rng;
      if (ret_valid) readData <= ret_rng ? '0 : lane_mask(ret_data, ret_be);
    end
endmodule
